// File: rtl/io_slave_regbank_if.sv
// Shared IO types and the tile IO request/response interface for the regbank slave.
package io_slave_regbank_pkg;

  localparam int unsigned THREAD_W = 4;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned REG_W    = 32;

  typedef logic [THREAD_W-1:0] thread_id_t;
  typedef logic [ADDR_W-1:0]   address_t;
  typedef logic [REG_W-1:0]    register_t;

  typedef enum logic {
    IO_READ  = 1'b0,
    IO_WRITE = 1'b1
  } io_operation_t;

endpackage

// Request/response bundle between the IO interface (master) and a slave.
interface io_slave_regbank_if;
  import io_slave_regbank_pkg::*;

  logic          slave_available_to_io_intf;
  logic          io_intf_valid;
  thread_id_t    io_intf_thread;
  io_operation_t io_intf_operation;
  address_t      io_intf_address;
  register_t     io_intf_data;
  logic          slave_resp_valid;
  thread_id_t    slave_wakeup_thread;
  register_t     slave_resp_data;
  logic          io_intf_resp_consumed;

  modport master (
    input  slave_available_to_io_intf,
    output io_intf_valid,
    output io_intf_thread,
    output io_intf_operation,
    output io_intf_address,
    output io_intf_data,
    input  slave_resp_valid,
    input  slave_wakeup_thread,
    input  slave_resp_data,
    output io_intf_resp_consumed
  );

  modport slave (
    output slave_available_to_io_intf,
    input  io_intf_valid,
    input  io_intf_thread,
    input  io_intf_operation,
    input  io_intf_address,
    input  io_intf_data,
    output slave_resp_valid,
    output slave_wakeup_thread,
    output slave_resp_data,
    input  io_intf_resp_consumed
  );

endinterface

// File: rtl/io_slave_regbank.sv
// Memory-mapped IO slave: scratch registers, 64-bit cycle counter with
// coherent high-word snapshot, and a console TX byte FIFO.
module io_slave_regbank
  import io_slave_regbank_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'hFF00_0000,
  parameter int unsigned TX_FIFO_DEPTH = 8,
  // Counter value loaded at reset; lets bring-up start near a carry boundary.
  parameter logic [63:0] CYCLE_INIT    = 64'h0
) (
  input  logic                clk,
  input  logic                reset_n,
  io_slave_regbank_if.slave   io,
  output logic                console_tx_valid,
  output logic [7:0]          console_tx_data,
  input  logic                console_tx_ready
);

  localparam int unsigned PTR_W = (TX_FIFO_DEPTH > 1) ? $clog2(TX_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [5:0] W_CYCLE_LO = 6'd4;
  localparam logic [5:0] W_CYCLE_HI = 6'd5;
  localparam logic [5:0] W_TX_DATA  = 6'd6;
  localparam logic [5:0] W_STATUS   = 6'd7;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic             hit;
  logic [5:0]       word;
  logic             rd_acc;
  logic             wr_acc;
  logic             tx_wr;
  logic             lo_rd;
  logic             status_rd;

  logic [63:0]      cycle_q;
  logic [31:0]      snap_q;
  register_t        scratch_q [4];

  logic [7:0]       fifo_mem [TX_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             ovf_q;
  logic             ovf_set;

  register_t        status_word;
  register_t        rd_data;
  register_t        resp_data_q;
  thread_id_t       resp_thread_q;

  logic             unused_addr_bits;

  // Address decode and request qualification.
  always_comb begin
    hit       = (io.io_intf_address[31:8] == BASE_ADDR[31:8]);
    word      = io.io_intf_address[7:2];
    rd_acc    = io.io_intf_valid && (io.io_intf_operation == IO_READ) && (state_q == IDLE);
    wr_acc    = io.io_intf_valid && (io.io_intf_operation == IO_WRITE) && hit;
    tx_wr     = wr_acc && (word == W_TX_DATA);
    lo_rd     = rd_acc && hit && (word == W_CYCLE_LO);
    status_rd = rd_acc && hit && (word == W_STATUS);
  end

  assign unused_addr_bits = ^io.io_intf_address[1:0];

  // FIFO flags and handshake; a pop frees the slot for a same-cycle push.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CNT_W'(TX_FIFO_DEPTH));
    pop     = !empty && console_tx_ready;
    push    = tx_wr && (!full || pop);
    ovf_set = tx_wr && full && !pop;
  end

  // Status word: overflow, occupancy, full, empty.
  always_comb begin
    status_word = {ovf_q, 15'b0, 8'(count_q), 6'b0, full, empty};
  end

  // Read data mux; misses, write-only and unmapped words read as zero.
  always_comb begin
    rd_data = '0;
    if (hit) begin
      case (word)
        6'd0, 6'd1, 6'd2, 6'd3: rd_data = scratch_q[word[1:0]];
        W_CYCLE_LO:             rd_data = cycle_q[31:0];
        W_CYCLE_HI:             rd_data = snap_q;
        W_STATUS:               rd_data = status_word;
        default:                rd_data = '0;
      endcase
    end
  end

  // Free-running cycle counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q <= CYCLE_INIT;
    end else begin
      cycle_q <= cycle_q + 64'd1;
    end
  end

  // High-word snapshot taken alongside every accepted low-word read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_q <= '0;
    end else if (lo_rd) begin
      snap_q <= cycle_q[63:32];
    end
  end

  // Scratch registers; writes land regardless of response state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        scratch_q[i] <= '0;
      end
    end else if (wr_acc && (word[5:2] == 4'd0)) begin
      scratch_q[word[1:0]] <= io.io_intf_data;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < TX_FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (push) begin
      fifo_mem[wr_ptr_q] <= io.io_intf_data[7:0];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow; a fresh overflow wins over the read-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end else if (status_rd) begin
      ovf_q <= 1'b0;
    end
  end

  // Response holder state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Response holder next state; reads seen while HELD are re-issues.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_acc) state_d = HELD;
      HELD:    if (io.io_intf_resp_consumed) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Held response payload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_data_q   <= '0;
      resp_thread_q <= '0;
    end else if (rd_acc) begin
      resp_data_q   <= rd_data;
      resp_thread_q <= io.io_intf_thread;
    end
  end

  assign io.slave_available_to_io_intf = (state_q == IDLE);
  assign io.slave_resp_valid           = (state_q == HELD);
  assign io.slave_wakeup_thread        = resp_thread_q;
  assign io.slave_resp_data            = resp_data_q;

  assign console_tx_valid = !empty;
  assign console_tx_data  = fifo_mem[rd_ptr_q];

endmodule
